// File: rtl/riscv_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the loader state encoding, word geometry and the byte-address helper.
package riscv_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int COUNT_W    = 16;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_e;

  // Word index to word-aligned byte address (bits [1:0] are always zero).
  function automatic logic [31:0] wordAddr(input logic [COUNT_W-1:0] idx);
    return 32'(idx) << 2;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port and boot status.
// master = host/byte source side, slave = the loader itself.
interface imem_loader_if;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error
  );

endinterface

// File: rtl/loader_word_asm.sv
// Assembles accepted stream bytes into little-endian 32-bit words.
// Byte j of a word lands in bits [8j+7:8j]; the completed word and a
// one-cycle valid pulse are registered on acceptance of the fourth byte.
module loader_word_asm
  import riscv_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic        lastByte_o,
  output logic        wordValid_o,
  output logic [31:0] word_o
);

  logic [1:0]  byteCnt_q;
  logic [23:0] partial_q;
  logic        wordValid_q;
  logic [31:0] word_q;

  assign lastByte_o  = (byteCnt_q == 2'(WORD_BYTES - 1));
  assign wordValid_o = wordValid_q;
  assign word_o      = word_q;

  // Place each accepted byte into its lane; the last lane completes the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      byteCnt_q   <= 2'd0;
      partial_q   <= 24'd0;
      wordValid_q <= 1'b0;
      word_q      <= 32'd0;
    end else begin
      wordValid_q <= 1'b0;
      if (accept_i) begin
        byteCnt_q <= byteCnt_q + 2'd1;
        case (byteCnt_q)
          2'd0:    partial_q[7:0]   <= byte_i;
          2'd1:    partial_q[15:8]  <= byte_i;
          2'd2:    partial_q[23:16] <= byte_i;
          default: begin
            word_q      <= {byte_i, partial_q};
            wordValid_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer.
// Parses a word count, streams 4N bytes into memory words, and holds the
// processor in reset until the image is complete. Defining LOADER_CHECKSUM_EN
// adds a trailing XOR checksum byte that must match before release.
module imem_loader
  import riscv_loader_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic           clk,
  input  logic           reset,
  imem_loader_if.slave   bus
);

  localparam logic [COUNT_W-1:0] DEPTH_W = COUNT_W'(DEPTH);

  loader_state_e      state_q, state_d;
  logic [7:0]         lenLo_q, lenLo_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] wordCount_q, wordCount_d;
  logic [31:0]        addr_q, addr_d;
  logic               inReady_q;
  logic               cpuReset_q;
  logic               done_q;
  logic               error_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  logic               accept;
  logic               dataAccept;
  logic               lastByte;
  logic               lastWord;
  logic               wordValid;
  logic [31:0]        word;
  logic [COUNT_W-1:0] lenFull;

  assign accept     = bus.in_valid && inReady_q;
  assign dataAccept = accept && (state_q == DATA);
  assign lenFull    = {bus.in_data, lenLo_q};
  assign lastWord   = ((wordCount_q + COUNT_W'(1)) == count_q);

  loader_word_asm u_word_asm (
    .clk         (clk),
    .reset       (reset),
    .accept_i    (dataAccept),
    .byte_i      (bus.in_data),
    .lastByte_o  (lastByte),
    .wordValid_o (wordValid),
    .word_o      (word)
  );

  assign bus.in_ready   = inReady_q;
  assign bus.imem_we    = wordValid;
  assign bus.imem_wdata = word;
  assign bus.imem_addr  = addr_q;
  assign bus.cpu_reset  = cpuReset_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

  // Next-state decode for the stream parser, counters, address and checksum.
  always_comb begin
    state_d     = state_q;
    lenLo_d     = lenLo_q;
    count_d     = count_q;
    wordCount_d = wordCount_q;
    addr_d      = addr_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      LEN0: begin
        if (accept) begin
          lenLo_d = bus.in_data;
          state_d = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          count_d     = lenFull;
          wordCount_d = '0;
          if (lenFull > DEPTH_W) begin
            state_d = ERR;
          end else if (lenFull == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.in_data;
`endif
          if (lastByte) begin
            addr_d      = wordAddr(wordCount_q);
            wordCount_d = wordCount_q + COUNT_W'(1);
            if (lastWord) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = CSUM;
`else
              state_d = DONE;
`endif
            end
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          state_d = (bus.in_data == csum_q) ? DONE : ERR;
        end
      end
`endif
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // Register parser state and derive every status output from it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LEN0;
      lenLo_q     <= 8'd0;
      count_q     <= '0;
      wordCount_q <= '0;
      addr_q      <= 32'd0;
      inReady_q   <= 1'b0;
      cpuReset_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      lenLo_q     <= lenLo_d;
      count_q     <= count_d;
      wordCount_q <= wordCount_d;
      addr_q      <= addr_d;
      inReady_q   <= (state_d != DONE) && (state_d != ERR);
      cpuReset_q  <= (state_q != DONE);
      done_q      <= (state_q == DONE);
      error_q     <= (state_q == ERR);
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the processor's instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and drives the instruction-memory write port. Holds the processor in reset until the image is fully written, then releases it. Sits between the host/serial byte source and the instruction memory's write side, opposite the processor's fetch (read) side.

## Interface
- DEPTH, 64: instruction memory capacity in 32-bit words; word counts above this are rejected.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; returns block to LEN0 and reasserts cpu_reset.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  32  byte address, word aligned (bits [1:0] = 0).
- imem_wdata  out  32  instruction word.
- cpu_reset  out  1  reset to the processor; high until load completes.
- done  out  1  image loaded and verified.
- error  out  1  load rejected; sticky until reset.

## Operation
- Stream format: word count N (16-bit, low byte first), then 4N data bytes (little-endian per word, word 0 first), then one checksum byte only when LOADER_CHECKSUM_EN is defined.
- States: LEN0 -> LEN1 -> DATA -> (CSUM) -> DONE; ERR reachable from LEN1 and CSUM.
- LEN0: accept low count byte. LEN1: accept high byte; N > DEPTH -> ERR; N = 0 -> CSUM (if enabled) else DONE; otherwise DATA.
- DATA: byte counter (2 bits) and word counter (16 bits). Byte j of word k lands in wdata[8j+7:8j]. On acceptance of byte 3: imem_we pulses, imem_addr = 4k, word counter increments. After word N-1 -> CSUM or DONE.
- Checksum = XOR of all 4N data bytes (length bytes excluded); initial value 0x00. CSUM: match -> DONE, mismatch -> ERR.
- DONE and ERR are terminal; only reset exits. in_ready = 1 in LEN0, LEN1, DATA, CSUM; 0 in DONE, ERR.
- in_valid without in_ready is ignored; no byte is lost or duplicated on stalls (in_valid low mid-word holds partial word indefinitely).

## Timing
- All outputs registered. Reset values: in_ready 0 during reset cycle then 1, imem_we 0, imem_addr 0, imem_wdata 0, cpu_reset 1, done 0, error 0.
- Byte 3 of word k accepted at edge t: imem_we = 1, imem_addr, imem_wdata valid for exactly the cycle after edge t.
- Final-state entry at edge t: done (or error) asserts and cpu_reset drops (DONE only) at edge t+1, guaranteeing the last write retires before the processor leaves reset.
- Back-to-back bytes at one per cycle sustained; word write rate ≤ 1 per 4 cycles.
- Reset mid-load: state, counters, checksum cleared next edge; cpu_reset stays high; partially written memory is not erased (reload overwrites).
- cpu_reset never pulses low in ERR.

## Configuration
- LOADER_CHECKSUM_EN defined: CSUM state present, trailing checksum byte required, mismatch -> ERR.
- Undefined: no CSUM state, no checksum register; last data byte leads directly to DONE; ERR reachable only via N > DEPTH.

## Structure
- Shared package riscv_loader_pkg: state enum (LEN0, LEN1, DATA, CSUM, DONE, ERR), WORD_BYTES = 4, COUNT_W = 16.
- One sub-module natural: loader_word_asm (byte-lane shift into 32-bit word, byte counter, word-complete pulse); FSM, address/word counters and checksum stay in top.

## Test plan
- N = 2, bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013 @ 0x0, 0x00100093 @ 0x4; done = 1, cpu_reset = 0 two cycles after last byte.
- N = 65 with DEPTH = 64 -> error = 1, in_ready = 0, no imem_we, cpu_reset stays 1.
- N = 1 with in_valid toggling every other cycle -> single write of correct word, no dropped/duplicated bytes.
- LOADER_CHECKSUM_EN, N = 1, data 01 02 04 08, checksum 0x0F -> done; checksum 0x0E -> error, cpu_reset 1.
- Reset asserted after 5 of 8 data bytes, then full N = 2 stream -> correct two writes, done = 1.
- N = 0 (no checksum build) -> done with no imem_we pulses.
